// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
// Contents:
//   fetch_state_t     FSM states IDLE, F0..F3 (byte reads), CAP (last byte), VALID
//   BYTES_PER_INSTR   bytes assembled per instruction
//   PC_INCR           PC step after an accepted instruction
//   RESET_PC_DEFAULT  default PC after reset
package fetch_pkg;

    localparam int BYTES_PER_INSTR = 4;
    localparam int PC_INCR = 4;
    localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F0    = 3'd1,
        F1    = 3'd2,
        F2    = 3'd3,
        F3    = 3'd4,
        CAP   = 3'd5,
        VALID = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/instr_byte_assembler.sv
// rtl/instr_byte_assembler.sv - byte-lane instruction word register
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear       discard partially assembled word (redirect)
//   load        write byte_in into the lane selected by lane
//   lane        byte lane, 0 = bits [DATA_W-1:0]
//   byte_in     byte from memory
//   word        assembled word
module instr_byte_assembler
    import fetch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [1:0]         lane,
    input  logic [DATA_W-1:0]  byte_in,
    output logic [INSTR_W-1:0] word
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word <= '0;
        end else if (load) begin
            word[lane*DATA_W +: DATA_W] <= byte_in;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle 4-byte instruction fetch with redirect
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   fetch_en                      allows a new fetch from IDLE or after acceptance
//   redirect_valid, redirect_pc   branch/jump redirect, aborts any fetch
//   mem_addr, mem_rd_en, mem_rdata  byte memory read port (data one cycle after address)
//   instr, instr_pc, instr_valid, instr_ready  instruction handshake to decode
//   busy                          high whenever the FSM is not IDLE
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter int               DATA_W   = 8,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd_en,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy
);

    fetch_state_t       state;
    fetch_state_t       next_state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  addr_offset;
    logic               asm_load;
    logic [1:0]         asm_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (redirect_valid) begin
            next_state = F0;
        end else begin
            case (state)
                IDLE:    if (fetch_en) next_state = F0;
                F0:      next_state = F1;
                F1:      next_state = F2;
                F2:      next_state = F3;
                F3:      next_state = CAP;
                CAP:     next_state = VALID;
                VALID:   if (instr_ready) next_state = fetch_en ? F0 : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Each read cycle also captures the byte addressed one cycle earlier,
    // so the lane being loaded trails the address offset by one.
    always_comb begin
        mem_rd_en   = 1'b0;
        addr_offset = '0;
        asm_load    = 1'b0;
        asm_lane    = 2'd0;
        case (state)
            F0: begin
                mem_rd_en   = 1'b1;
            end
            F1: begin
                mem_rd_en   = 1'b1;
                addr_offset = ADDR_W'(1);
                asm_load    = 1'b1;
                asm_lane    = 2'd0;
            end
            F2: begin
                mem_rd_en   = 1'b1;
                addr_offset = ADDR_W'(2);
                asm_load    = 1'b1;
                asm_lane    = 2'd1;
            end
            F3: begin
                mem_rd_en   = 1'b1;
                addr_offset = ADDR_W'(3);
                asm_load    = 1'b1;
                asm_lane    = 2'd2;
            end
            CAP: begin
                asm_load    = 1'b1;
                asm_lane    = 2'd3;
            end
            default: begin
            end
        endcase
        mem_addr    = mem_rd_en ? pc + addr_offset : '0;
        instr_valid = (state == VALID);
        busy        = (state != IDLE);
    end

    // A redirect outranks acceptance: the held instruction is dropped and
    // pc takes the redirect target instead of advancing.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (state == VALID && instr_ready) begin
            pc <= pc + ADDR_W'(PC_INCR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_pc <= '0;
        end else if (state == CAP && !redirect_valid) begin
            instr_pc <= pc;
        end
    end

    instr_byte_assembler #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W)
    ) u_assembler (
        .clk     (clk),
        .reset   (reset),
        .clear   (redirect_valid),
        .load    (asm_load),
        .lane    (asm_lane),
        .byte_in (mem_rdata),
        .word    (instr)
    );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multicycle instruction fetch stage that sits directly upstream of the 256 x 8-bit unified instruction/data memory.
- Walks the PC and issues four byte reads per instruction.
- Assembles the returned bytes into a 32-bit MIPS instruction and hands it to decode over a valid/ready handshake.
- Supports branch/jump redirect from the execute stage.

Parameters:
ADDR_W, 8, byte-address width; matches the memory's 256-entry address space
DATA_W, 8, memory data width (one byte per read)
INSTR_W, 32, assembled instruction width (= 4 x DATA_W)
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
fetch_en  input  1  permits starting a new fetch from IDLE
redirect_valid  input  1  branch/jump taken; abort the current fetch
redirect_pc  input  ADDR_W  new PC, sampled when redirect_valid=1
mem_addr  output  ADDR_W  byte address presented to memory
mem_rd_en  output  1  high while mem_addr carries a fetch address
mem_rdata  input  DATA_W  memory read data, valid one cycle after its address
instr  output  INSTR_W  assembled instruction
instr_pc  output  ADDR_W  byte address of instr's first byte
instr_valid  output  1  instr/instr_pc valid; held until accepted
instr_ready  input  1  decode accepts instr when instr_valid & instr_ready
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (reset=1 on a rising edge):
  - state=IDLE, pc=RESET_PC.
  - mem_addr=0, mem_rd_en=0.
  - instr=0, instr_pc=0, instr_valid=0, busy=0.
  - Reset applied in any state aborts a fetch in progress; partial bytes are discarded.
- States: IDLE, F0, F1, F2, F3, CAP, VALID.
  - IDLE: if fetch_en=1, go to F0; otherwise stay.
  - F0: mem_addr=pc, mem_rd_en=1.
  - F1: mem_addr=pc+1, mem_rd_en=1; capture mem_rdata into instr[7:0].
  - F2: mem_addr=pc+2, mem_rd_en=1; capture mem_rdata into instr[15:8].
  - F3: mem_addr=pc+3, mem_rd_en=1; capture mem_rdata into instr[23:16].
  - CAP: mem_rd_en=0; capture mem_rdata into instr[31:24]; instr_pc<=pc; go to VALID.
  - VALID: instr_valid=1.
    - On instr_ready=1: pc<=pc+4, then go to F0 if fetch_en=1, else IDLE.
    - On instr_ready=0: hold; instr and instr_pc stay stable.
- Byte order: little-endian; the byte at pc is instr[7:0].
- Address arithmetic: modulo 2^ADDR_W. pc+1..pc+3 and pc+4 wrap silently; for example, pc=8'hFE fetches FE, FF, 00, 01 and the next pc is 8'h02.
- Latency and throughput:
  - Entering F0 in cycle t gives instr_valid=1 in cycle t+5.
  - With instr_ready held high and fetch_en=1, throughput is one instruction per 6 cycles.
- mem_addr is combinational from state and pc, and is 0 when mem_rd_en=0.
- Redirect (any non-IDLE state, or IDLE):
  - pc<=redirect_pc, instr_valid<=0, next state F0.
  - Partially captured bytes are discarded.
  - Redirect has priority over instr_ready in VALID: the held instruction is dropped, not counted as accepted, and pc is not incremented.
  - Redirect is honoured regardless of fetch_en.
- Simultaneous reset and redirect: reset wins.
- fetch_en deasserted mid-fetch (F0-CAP) has no effect; the fetch completes to VALID. fetch_en is sampled only in IDLE and on acceptance in VALID.
- The fetch unit never writes memory. Memory-port arbitration with load/store is outside this block and is gated by busy.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE, F0, F1, F2, F3, CAP, VALID);
  - BYTES_PER_INSTR=4 and the PC increment constant 4;
  - RESET_PC default.
- One sub-module, instr_byte_assembler:
  - a 32-bit register with a 2-bit byte-lane select and load enable;
  - clear on reset or redirect.
- The FSM and PC live in the top module.

Test Plan:
- Basic fetch: memory bytes 0x00..0x03 = 0x20,0x08,0x00,0x05, fetch_en=1, instr_ready=1 -> mem_addr 0,1,2,3 on consecutive cycles; instr=32'h05000820, instr_pc=0, instr_valid high 5 cycles after F0; next fetch starts at pc=4.
- Backpressure: instr_ready=0 for 10 cycles in VALID -> instr, instr_pc and instr_valid stable; mem_rd_en=0 throughout; pc stays 0 until the accepting cycle, then 4.
- Wrap-around: redirect_pc=8'hFE, bytes FE..01 = 0xAA,0xBB,0xCC,0xDD -> addresses FE,FF,00,01; instr=32'hDDCCBBAA, instr_pc=8'hFE; next pc=8'h02.
- Redirect mid-fetch (in F2) to 8'h40 -> next cycle is F0 with mem_addr=8'h40; no instr_valid for the aborted fetch; the first valid instr has instr_pc=8'h40.
- Redirect concurrent with accept in VALID (redirect_pc=8'h10, instr_ready=1) -> instr_valid drops; next fetch starts at 8'h10, not pc+4.
- Reset mid-fetch (in F3) -> next cycle state IDLE, pc=RESET_PC, all outputs 0; with fetch_en=1, fetching resumes at RESET_PC.
